// File: rtl/cube_pkg.sv
// ----------------------------------------------------------------------------
// cube_pkg
//   Shared definitions for the 8x8x8 LED cube datapath: cube geometry, the
//   512-bit frame type, the frame-buffer state encoding and a cell-index
//   helper (bit index = z*64 + y*8 + x).
//   No ports; imported by the cube modules.
// ----------------------------------------------------------------------------
package cube_pkg;

    localparam int CUBE_DIM    = 8;
    localparam int CUBE_CELLS  = CUBE_DIM * CUBE_DIM * CUBE_DIM;
    localparam int ROW_CELLS   = CUBE_DIM;
    localparam int LAYER_CELLS = CUBE_DIM * CUBE_DIM;

    typedef logic [CUBE_CELLS-1:0] cube_frame_t;

    // The pending buffer is either empty or holds an undisplayed generation.
    typedef enum logic {
        FB_EMPTY = 1'b0,
        FB_FULL  = 1'b1
    } fb_state_t;

    function automatic int unsigned cell_index(input int unsigned x,
                                               input int unsigned y,
                                               input int unsigned z);
        return z * LAYER_CELLS + y * ROW_CELLS + x;
    endfunction

endpackage

// File: rtl/cube_stall_detect.sv
// ----------------------------------------------------------------------------
// cube_stall_detect
//   Detects a cube that has stopped evolving. On every swap the incoming frame
//   is compared with the frame currently shown; consecutive equal swaps are
//   counted (saturating) and stalled is raised once STALL_GENS of them have
//   been seen in a row. A differing frame clears the count.
//
//   Ports:
//     clk         board clock
//     rst_n       asynchronous active-low reset
//     swap        high on the edge where the display buffer is reloaded
//     pend_frame  frame about to be displayed
//     disp_frame  frame currently displayed
//     stalled     registered stall flag
// ----------------------------------------------------------------------------
module cube_stall_detect #(
    parameter int CELLS      = 512,
    parameter int STALL_GENS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             swap,
    input  logic [CELLS-1:0] pend_frame,
    input  logic [CELLS-1:0] disp_frame,
    output logic             stalled
);

    localparam int               CNT_W   = $clog2(STALL_GENS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STALL_GENS);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    // Count saturates at STALL_GENS, which is all the flag needs to see.
    always_comb begin
        cnt_next = cnt;
        if (pend_frame == disp_frame) begin
            if (cnt < CNT_MAX) begin
                cnt_next = cnt + 1'b1;
            end
        end else begin
            cnt_next = '0;
        end
    end

    // Flag is derived from the next count so it moves on the same swap edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            stalled <= 1'b0;
        end else if (swap) begin
            cnt     <= cnt_next;
            stalled <= (cnt_next >= CNT_MAX);
        end
    end

endmodule

// File: rtl/cube_frame_buffer.sv
// ----------------------------------------------------------------------------
// cube_frame_buffer
//   Double-buffered frame store between the Life simulator and the cube
//   scanner. A new generation is captured into a pending buffer on each rising
//   edge of the slow simulation clock and is copied to the display buffer only
//   when the scanner finishes a frame, so a frame is never torn.
//
//   Optional feature: define CUBE_FB_STALL_DETECT_EN to build the stall
//   detector (cube_stall_detect); otherwise Stalled is tied low.
//
//   Ports:
//     Clk        board clock, all state on posedge
//     Reset      asynchronous active-low reset
//     SlowClk    slow simulation clock level (already in the Clk domain)
//     Cells      current generation from the simulator
//     FrameDone  one-cycle pulse after the last layer of a scan frame
//     Freeze     blocks swaps while high; capture continues
//     DispCells  stable frame for the scanner
//     Swapped    one-cycle pulse in the cycle after a swap edge
//     Pending    pending buffer holds an undisplayed generation
//     Overrun    sticky: a pending generation was overwritten undisplayed
//     Stalled    cube has stopped changing (0 without the stall detector)
// ----------------------------------------------------------------------------
module cube_frame_buffer
    import cube_pkg::*;
#(
    parameter int CELLS      = CUBE_CELLS,
    parameter int STALL_GENS = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             SlowClk,
    input  logic [CELLS-1:0] Cells,
    input  logic             FrameDone,
    input  logic             Freeze,
    output logic [CELLS-1:0] DispCells,
    output logic             Swapped,
    output logic             Pending,
    output logic             Overrun,
    output logic             Stalled
);

    fb_state_t        state;
    logic             slow_q;
    logic [CELLS-1:0] pend_buf;
    logic             gen_rise;
    logic             do_swap;

    // SlowClk is a register output in this domain, so a single delay stage
    // is enough for a clean rising-edge detect.
    assign gen_rise = SlowClk & ~slow_q;
    assign do_swap  = FrameDone & (state == FB_FULL) & ~Freeze;
    assign Pending  = (state == FB_FULL);

    // Capture, swap and fill-state tracking. A generation arriving on the
    // same edge as a swap refills the buffer right away: the old contents go
    // to the display, so nothing is lost and no overrun is flagged.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= FB_EMPTY;
            slow_q    <= 1'b0;
            pend_buf  <= '0;
            DispCells <= '0;
            Swapped   <= 1'b0;
            Overrun   <= 1'b0;
        end else begin
            slow_q  <= SlowClk;
            Swapped <= do_swap;
            if (gen_rise) begin
                pend_buf <= Cells;
            end
            if (do_swap) begin
                DispCells <= pend_buf;
            end
            case (state)
                FB_EMPTY: begin
                    if (gen_rise) begin
                        state <= FB_FULL;
                    end
                end
                FB_FULL: begin
                    if (do_swap && !gen_rise) begin
                        state <= FB_EMPTY;
                    end else if (gen_rise && !do_swap) begin
                        Overrun <= 1'b1;
                    end
                end
                default: state <= FB_EMPTY;
            endcase
        end
    end

`ifdef CUBE_FB_STALL_DETECT_EN
    // Compares the outgoing pending frame with the frame it replaces.
    cube_stall_detect #(
        .CELLS      (CELLS),
        .STALL_GENS (STALL_GENS)
    ) u_stall (
        .clk        (Clk),
        .rst_n      (Reset),
        .swap       (do_swap),
        .pend_frame (pend_buf),
        .disp_frame (DispCells),
        .stalled    (Stalled)
    );
`else
    // Folds to constant 0; the parameter is referenced so both builds share
    // the same parameter list without an unused-parameter warning.
    assign Stalled = 1'b0 && (STALL_GENS > 0);
`endif

endmodule

// File: doc/cube_frame_buffer.md
# cube_frame_buffer

Double-buffered frame store between `conway_sim` and `cube_output`. It captures each new 512-cell generation on the rising edge of the slow simulation clock and holds it in a pending buffer. It swaps that buffer into the display buffer only at a scanner frame boundary, so `cube_output` never multiplexes a half-old, half-new cube. It runs entirely on the fast board clock.

## Interface
- `CELLS`, 512: cube cell count (8×8×8), bit index = z*64 + y*8 + x.
- `STALL_GENS`, 4: consecutive identical generations before `Stalled` asserts. Used only with the stall-detect macro.
- `Clk` input 1: board clock. All state updates on posedge.
- `Reset` input 1: one clock; reset is asynchronous and active-low.
- `SlowClk` input 1: slow simulation clock level. It is a register output in the `Clk` domain, so no synchronizer is needed.
- `Cells` input CELLS: current generation from `conway_sim`.
- `FrameDone` input 1: one-cycle pulse from the scanner after the last layer of a frame.
- `Freeze` input 1: when 1, swaps are blocked and the display holds.
- `DispCells` output CELLS: stable frame fed to `cube_output`.
- `Swapped` output 1: one-cycle pulse, high in the cycle after a swap edge.
- `Pending` output 1: the pending buffer holds an undisplayed generation.
- `Overrun` output 1: sticky. Set when a pending generation is overwritten before it is displayed.
- `Stalled` output 1: the cube has stopped changing. Constant 0 without the macro.

## Operation
- Edge detect:
  - `slow_q` <= `SlowClk`.
  - `GenRise` = `SlowClk & ~slow_q`, combinational.
- Capture: on any edge with `GenRise`=1, `pend_buf` <= `Cells`.
- Swap condition, `do_swap` = `FrameDone & Pending & ~Freeze`. On a swap edge:
  - `DispCells` <= `pend_buf`.
  - `Swapped` <= 1.
- States, encoded by `Pending`:
  - EMPTY (0):
    - `GenRise` → capture, go to FULL.
    - `FrameDone` alone → no action.
    - `GenRise` and `FrameDone` together → capture only. There is no same-cycle bypass to the display.
  - FULL (1):
    - `do_swap` without `GenRise` → swap, go to EMPTY.
    - `do_swap` with `GenRise` → swap the old `pend_buf`, capture the new `Cells`, stay FULL, no overrun.
    - `GenRise` without `do_swap` → overwrite `pend_buf`, set `Overrun`, stay FULL.
- `Freeze`:
  - Capture still happens while `Freeze`=1; only swaps are blocked.
  - On release, the next `FrameDone` displays the newest generation.
- `Overrun` clears only on reset.
- Reset mid-operation:
  - All registers clear immediately.
  - A `GenRise` in the first cycle after deassertion is honoured only if `SlowClk`=1 and `slow_q`=0.

## Timing
- Reset values:
  - `DispCells`=0, `pend_buf`=0, `Pending`=0.
  - `Swapped`=0, `Overrun`=0, `Stalled`=0.
  - `slow_q`=0, stall counter=0.
- Capture latency: `Cells` is sampled on the first `Clk` edge after `SlowClk` rises.
- Swap latency: `DispCells` and `Swapped` change on the `FrameDone` edge and are visible the following cycle.
- Worst-case display lag: one full scan frame after capture.
- `Swapped` is exactly one cycle wide. Back-to-back swaps are impossible because `Pending` must be refilled first.
- `FrameDone` is expected as a single-cycle pulse. A held level swaps at most once per capture.

## Configuration
- Macro: `CUBE_FB_STALL_DETECT_EN`.
- With the macro defined, on every swap edge:
  - Compare `pend_buf` against the current `DispCells` (512-bit equality).
  - Equal → increment a saturating counter of width $clog2(STALL_GENS+1). Not equal → clear it to 0.
  - `Stalled` = (counter ≥ `STALL_GENS`), registered. It updates in the same edge as the counter.
- Without the macro:
  - No comparator and no counter.
  - `Stalled` is tied to 0.

## Structure
- Shared package `cube_pkg`:
  - `CUBE_DIM`=8, `CUBE_CELLS`=512.
  - `cube_frame_t` (logic [511:0]).
  - Cell-index helper constants.
- The one natural sub-module is `cube_stall_detect` (comparator plus saturating counter). It is instantiated only under `CUBE_FB_STALL_DETECT_EN`.
- Capture, swap, and FSM logic stay in the top of the block.

## Test plan
- Reset then idle: hold `Reset`=0 then release with no `SlowClk` edge → `DispCells`=0, `Pending`=0, `Swapped` never pulses, `FrameDone` pulses ignored.
- Basic flow: `Cells`=512'h1, `SlowClk` rises, `FrameDone` pulses 10 cycles later → `Pending`=1 after capture; `DispCells`=512'h1 and `Swapped`=1 for one cycle after the `FrameDone` edge; then `Pending`=0.
- Overrun: capture 512'hA, then capture 512'hB before any `FrameDone`, then `FrameDone` → `Overrun`=1 sticky; `DispCells`=512'hB.
- Simultaneous: FULL with 512'hA, `GenRise` with `Cells`=512'hC in the same cycle as `FrameDone` → `DispCells`=512'hA, `Pending` stays 1, `Overrun`=0; the next `FrameDone` shows 512'hC.
- Freeze: `Freeze`=1, capture 512'h5, three `FrameDone` pulses → `DispCells` unchanged; drop `Freeze`, one `FrameDone` → `DispCells`=512'h5.
- Stall (macro on, `STALL_GENS`=4): five identical generations, each followed by `FrameDone` → `Stalled`=1 after the 4th equal swap; one differing generation → `Stalled`=0 on that swap.
